// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO register map,
// STATUS bit positions and the address-decode region type.
package dmem_pkg;

  localparam logic [7:0] OFF_TXDATA   = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_CYCLE_LO = 8'h08;
  localparam logic [7:0] OFF_CYCLE_HI = 8'h0C;
  localparam logic [7:0] OFF_HALT     = 8'h10;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_OCC_LSB = 4;

  typedef enum logic [1:0] {
    REG_SRAM = 2'd0,
    REG_MMIO = 2'd1,
    REG_NONE = 2'd2
  } region_e;

  // The occupancy field is only four bits wide, so larger FIFOs report 15.
  function automatic logic [3:0] sat_occ(input logic [31:0] c);
    return (c > 32'd15) ? 4'd15 : c[3:0];
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side data-memory port plus the console, halt and cycle-counter outputs.
interface dmem_responder_if;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_web;
  logic [31:0] dm_rdata;
  logic        console_valid;
  logic [7:0]  console_data;
  logic        console_ready;
  logic        halt;
  logic [31:0] halt_code;
  logic [63:0] cycle_count;

  modport master (
    output dm_addr, dm_wdata, dm_web, console_ready,
    input  dm_rdata, console_valid, console_data, halt, halt_code, cycle_count
  );

  modport slave (
    input  dm_addr, dm_wdata, dm_web, console_ready,
    output dm_rdata, console_valid, console_data, halt, halt_code, cycle_count
  );
endinterface

// File: rtl/dmem_responder_tx_fifo.sv
// Console transmit FIFO; head byte is held at zero whenever the FIFO is empty.
module tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic                     o_push_ok,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [7:0]               o_head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = o_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign w_pop     = i_pop && !o_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign o_push_ok = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (o_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (o_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({o_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane SRAM plus an MMIO window holding the
// console FIFO, the free-running cycle counter and the sticky halt register.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 16384,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);
  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam int          CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] SRAM_LIMIT = 32'(DEPTH_WORDS * 4);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [63:0] r_cycle;
  logic        r_halt;
  logic [31:0] r_halt_code;
  logic        r_ovf;

  region_e         w_region;
  logic [IDX_W-1:0] w_idx;
  logic [5:0]      w_reg;
  logic            w_wr;
  logic            w_mmio;
  logic            w_push;
  logic            w_push_ok;
  logic            w_full;
  logic            w_empty;
  logic [CNT_W-1:0] w_count;
  logic [7:0]      w_head;
  logic            w_status_wr;
  logic            w_halt_wr;
  logic [31:0]     w_status;
  logic [31:0]     w_rdata;

  always_comb begin
    w_region = REG_NONE;
    if (bus.dm_addr < SRAM_LIMIT)                    w_region = REG_SRAM;
    else if (bus.dm_addr[31:8] == MMIO_BASE[31:8])   w_region = REG_MMIO;
  end

  assign w_idx       = bus.dm_addr[IDX_W+1:2];
  assign w_reg       = bus.dm_addr[7:2];
  assign w_wr        = (bus.dm_web != 4'hF);
  assign w_mmio      = (w_region == REG_MMIO);
  assign w_push      = w_mmio && (w_reg == OFF_TXDATA[7:2]) && !bus.dm_web[0];
  assign w_status_wr = w_mmio && (w_reg == OFF_STATUS[7:2]) && w_wr;
  assign w_halt_wr   = w_mmio && (w_reg == OFF_HALT[7:2]) && w_wr && !r_halt;

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_data    (bus.dm_wdata[7:0]),
    .i_pop     (bus.console_ready),
    .o_push_ok (w_push_ok),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count),
    .o_head    (w_head)
  );

  always_comb begin
    w_status                       = '0;
    w_status[ST_FULL]              = w_full;
    w_status[ST_EMPTY]             = w_empty;
    w_status[ST_OVF]               = r_ovf;
    w_status[ST_OCC_LSB +: 4]      = sat_occ(32'(w_count));
  end

  always_comb begin
    w_rdata = '0;
    case (w_region)
      REG_SRAM: w_rdata = r_mem[w_idx];
      REG_MMIO: begin
        case (w_reg)
          OFF_STATUS[7:2]:   w_rdata = w_status;
          OFF_CYCLE_LO[7:2]: w_rdata = r_cycle[31:0];
          OFF_CYCLE_HI[7:2]: w_rdata = r_cycle[63:32];
          default:           w_rdata = '0;
        endcase
      end
      default:  w_rdata = '0;
    endcase
  end

  // SRAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_region == REG_SRAM) begin
      for (int i = 0; i < 4; i++) begin
        if (!bus.dm_web[i]) r_mem[w_idx][8*i +: 8] <= bus.dm_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle     <= '0;
      r_halt      <= 1'b0;
      r_halt_code <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (w_halt_wr) begin
        r_halt      <= 1'b1;
        r_halt_code <= bus.dm_wdata;
      end
      if (w_status_wr)                r_ovf <= 1'b0;
      else if (w_push && !w_push_ok)  r_ovf <= 1'b1;
    end
  end

  assign bus.dm_rdata      = w_rdata;
  assign bus.console_valid = !w_empty;
  assign bus.console_data  = w_head;
  assign bus.halt          = r_halt;
  assign bus.halt_code     = r_halt_code;
  assign bus.cycle_count   = r_cycle;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a scoreboard queue for console bytes.
module tb_dmem_responder;
  localparam logic [31:0] MMIO    = 32'h1000_0000;
  localparam logic [31:0] A_TX    = MMIO + 32'h00;
  localparam logic [31:0] A_ST    = MMIO + 32'h04;
  localparam logic [31:0] A_CLO   = MMIO + 32'h08;
  localparam logic [31:0] A_CHI   = MMIO + 32'h0C;
  localparam logic [31:0] A_HALT  = MMIO + 32'h10;

  logic clk;
  logic rst;
  int   n_err;
  int   n_checks;
  int   n_cyc;
  logic [7:0] sb[$];
  logic [7:0] last;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS (16384),
    .MMIO_BASE   (32'h1000_0000),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
    n_cyc++;
  endtask

  task automatic idle();
    bus.dm_web   = 4'hF;
    bus.dm_wdata = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] web);
    bus.dm_addr  = a;
    bus.dm_wdata = d;
    bus.dm_web   = web;
    cyc();
    idle();
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.dm_addr = a;
    bus.dm_web  = 4'hF;
    #1;
    check(tag, 64'(bus.dm_rdata), 64'(exp));
  endtask

  task automatic push_tx(input logic [7:0] b, input bit expect_kept);
    wr(A_TX, {24'h0, b}, 4'b1110);
    if (expect_kept) sb.push_back(b);
  endtask

  task automatic drain(output logic [7:0] last_b);
    logic [7:0] exp_b;
    last_b = 8'h00;
    bus.console_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!bus.console_valid) break;
      exp_b = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      check("drain_data", 64'(bus.console_data), 64'(exp_b));
      last_b = bus.console_data;
      cyc();
    end
    bus.console_ready = 1'b0;
    #1;
    check("drain_valid_low", 64'(bus.console_valid), 64'd0);
    check("drain_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    n_err = 0;
    n_checks = 0;
    n_cyc = 0;
    rst = 1'b1;
    bus.dm_addr = '0;
    bus.console_ready = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", 64'(bus.console_valid), 64'd0);
    check("rst_data", 64'(bus.console_data), 64'd0);
    check("rst_halt", 64'(bus.halt), 64'd0);
    check("rst_halt_code", 64'(bus.halt_code), 64'd0);
    check("rst_cycle", bus.cycle_count, 64'd0);
    rst = 1'b0;
    n_cyc = 0;

    // Counter after 100 cycles
    repeat (100) cyc();
    check("cycle_out", bus.cycle_count, 64'd100);
    rd_check("cycle_lo", A_CLO, 32'd100);
    rd_check("cycle_hi", A_CHI, 32'd0);
    rd_check("status_reset", A_ST, 32'h02);

    // SRAM byte lanes
    wr(32'h100, 32'hDEADBEEF, 4'b0000);
    wr(32'h100, 32'h0000AA00, 4'b1101);
    rd_check("sram_lanes", 32'h100, 32'hDEADAAEF);

    // Read during write
    wr(32'h40, 32'h22222222, 4'b0000);
    bus.dm_addr  = 32'h40;
    bus.dm_wdata = 32'h11111111;
    bus.dm_web   = 4'b0000;
    #1;
    check("rdw_old", 64'(bus.dm_rdata), 64'h22222222);
    cyc();
    idle();
    rd_check("rdw_new", 32'h40, 32'h11111111);

    // SRAM upper boundary and unmapped space
    wr(32'hFFFC, 32'hA5A5_0F0F, 4'b0000);
    rd_check("sram_top", 32'hFFFC, 32'hA5A5_0F0F);
    wr(32'h0, 32'h12345678, 4'b0000);
    wr(32'h10000, 32'hCAFEF00D, 4'b0000);
    rd_check("unmapped_no_alias", 32'h0, 32'h12345678);
    rd_check("unmapped_read", 32'h10000, 32'h0);
    rd_check("mmio_hole_read", MMIO + 32'h20, 32'h0);
    rd_check("txdata_read", A_TX, 32'h0);

    // Fill and overflow
    for (int i = 0; i < 9; i++) push_tx(8'(8'h41 + i), i < 8);
    rd_check("status_full_ovf", A_ST, 32'h85);
    #1;
    check("head_first", 64'(bus.console_data), 64'h41);
    drain(last);
    check("drain_last_48", 64'(last), 64'h48);
    rd_check("status_empty_ovf", A_ST, 32'h06);
    wr(A_ST, 32'h0, 4'b0000);
    rd_check("status_ovf_clr", A_ST, 32'h02);

    // Simultaneous push and pop while full
    for (int i = 0; i < 8; i++) push_tx(8'(8'h50 + i), 1'b1);
    rd_check("status_full", A_ST, 32'h81);
    bus.dm_addr       = A_TX;
    bus.dm_wdata      = 32'h5A;
    bus.dm_web        = 4'b1110;
    bus.console_ready = 1'b1;
    #1;
    check("pushpop_head", 64'(bus.console_data), 64'(sb.pop_front()));
    sb.push_back(8'h5A);
    cyc();
    idle();
    bus.console_ready = 1'b0;
    rd_check("status_pushpop", A_ST, 32'h81);
    drain(last);
    check("drain_last_5a", 64'(last), 64'h5A);

    // Halt
    check("halt_pre", 64'(bus.halt), 64'd0);
    wr(A_HALT, 32'h1, 4'b0000);
    check("halt_set", 64'(bus.halt), 64'd1);
    check("halt_code1", 64'(bus.halt_code), 64'd1);
    wr(A_HALT, 32'h2, 4'b0000);
    check("halt_code_kept", 64'(bus.halt_code), 64'd1);
    rd_check("cycle_lo_live", A_CLO, n_cyc[31:0]);
    rd_check("sram_after_halt", 32'h100, 32'hDEADAAEF);

    // Reset mid-drain
    for (int i = 0; i < 3; i++) push_tx(8'(8'h61 + i), 1'b1);
    bus.console_ready = 1'b1;
    #1;
    check("pre_rst_valid", 64'(bus.console_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 64'(bus.console_valid), 64'd0);
    check("rst_mid_data", 64'(bus.console_data), 64'd0);
    sb.delete();
    cyc();
    rst = 1'b0;
    n_cyc = 0;
    bus.console_ready = 1'b0;
    rd_check("status_after_rst", A_ST, 32'h02);
    rd_check("sram_kept", 32'h100, 32'hDEADAAEF);
    check("halt_after_rst", 64'(bus.halt), 64'd0);
    check("halt_code_after_rst", 64'(bus.halt_code), 64'd0);
    repeat (5) cyc();
    check("cycle_after_rst", bus.cycle_count, 64'(n_cyc));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
